// File: rtl/fifo_level.sv
// Single-clock FIFO with registered fill level, almost-full/almost-empty flags,
// sticky overflow/underflow errors and a choice of FWFT or registered-read output.
module fifo_level #(
  parameter int DEPTH_WIDTH   = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int FWFT          = 1,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i,
  input  logic                   wr_en_i,
  input  logic                   rd_en_i,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  output logic                   rd_valid_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   almost_full_o,
  output logic                   almost_empty_o,
  output logic [DEPTH_WIDTH:0]   level_o,
  output logic                   overflow_o,
  output logic                   underflow_o
);

  localparam int DEPTH = 1 << DEPTH_WIDTH;
  localparam int PW    = DEPTH_WIDTH + 1;

  // Out-of-range thresholds saturate: the flag value at level 0 is the reset value.
  localparam logic AFULL_AT_ZERO  = (0 >= AFULL_THRESH);
  localparam logic AEMPTY_AT_ZERO = (0 <= AEMPTY_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW-1:0]         r_level;
  logic                  r_full;
  logic                  r_empty;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_unf;

  logic                  w_rd_ok;
  logic                  w_wr_ok;
  logic [PW-1:0]         w_wptr_nxt;
  logic [PW-1:0]         w_rptr_nxt;
  logic [PW-1:0]         w_level_nxt;
  logic                  w_full_nxt;
  logic                  w_empty_nxt;
  logic                  w_afull_nxt;
  logic                  w_aempty_nxt;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned; that is what keeps synthesis from inferring latches.
  always_comb begin
    w_rd_ok     = rd_en_i & ~r_empty;
    w_wr_ok     = wr_en_i & (~r_full | w_rd_ok);
    w_wptr_nxt  = r_wptr + {{DEPTH_WIDTH{1'b0}}, w_wr_ok};
    w_rptr_nxt  = r_rptr + {{DEPTH_WIDTH{1'b0}}, w_rd_ok};
    if (clr_i) begin
      w_wptr_nxt = '0;
      w_rptr_nxt = '0;
    end
    w_level_nxt  = w_wptr_nxt - w_rptr_nxt;
    w_full_nxt   = (w_wptr_nxt[PW-1] != w_rptr_nxt[PW-1]) &&
                   (w_wptr_nxt[PW-2:0] == w_rptr_nxt[PW-2:0]);
    w_empty_nxt  = (w_wptr_nxt == w_rptr_nxt);
    w_afull_nxt  = (int'(w_level_nxt) >= AFULL_THRESH);
    w_aempty_nxt = (int'(w_level_nxt) <= AEMPTY_THRESH);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the statements are written in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_afull  <= AFULL_AT_ZERO;
      r_aempty <= AEMPTY_AT_ZERO;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_level  <= w_level_nxt;
      r_full   <= w_full_nxt;
      r_empty  <= w_empty_nxt;
      r_afull  <= w_afull_nxt;
      r_aempty <= w_aempty_nxt;
      if (clr_i) begin
        r_ovf <= 1'b0;
        r_unf <= 1'b0;
      end else begin
        r_ovf <= r_ovf | (wr_en_i & ~w_wr_ok);
        r_unf <= r_unf | (rd_en_i & ~w_rd_ok);
      end
    end
  end

  // NOTE: the storage array has no reset; pointers and level alone define which
  // words are valid, so clearing it would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !clr_i) begin
      r_mem[r_wptr[PW-2:0]] <= wr_data_i;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is driven straight from storage while the FIFO holds data.
      assign rd_data_o  = r_empty ? '0 : r_mem[r_rptr[PW-2:0]];
      assign rd_valid_o = ~r_empty;
    end else begin : g_registered
      logic [DATA_WIDTH-1:0] r_rd_data;
      logic                  r_rd_valid;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else if (clr_i) begin
          r_rd_data  <= '0;
          r_rd_valid <= 1'b0;
        end else begin
          r_rd_valid <= w_rd_ok;
          if (w_rd_ok) begin
            r_rd_data <= r_mem[r_rptr[PW-2:0]];
          end
        end
      end

      assign rd_data_o  = r_rd_data;
      assign rd_valid_o = r_rd_valid;
    end
  endgenerate

  assign full_o         = r_full;
  assign empty_o        = r_empty;
  assign almost_full_o  = r_afull;
  assign almost_empty_o = r_aempty;
  assign level_o        = r_level;
  assign overflow_o     = r_ovf;
  assign underflow_o    = r_unf;

endmodule

// File: tb/tb_fifo_level.sv
// Scoreboard bench for fifo_level: one FWFT and one registered-read instance
// share stimulus and are compared against a queue-based reference model.
module tb_fifo_level;

  localparam int DW    = 4;
  localparam int DATAW = 8;
  localparam int DEPTH = 1 << DW;
  localparam int AF    = 12;
  localparam int AE    = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_i = 1'b0;
  logic [DATAW-1:0] wr_data = '0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;

  logic [DATAW-1:0] rd_data_f, rd_data_r;
  logic             rd_valid_f, rd_valid_r;
  logic             full_f, full_r, empty_f, empty_r;
  logic             af_f, af_r, ae_f, ae_r, ovf_f, ovf_r, unf_f, unf_r;
  logic [DW:0]      level_f, level_r;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATAW-1:0] m_q[$];
  bit               m_ovf = 1'b0;
  bit               m_unf = 1'b0;
  logic [DATAW-1:0] exp_q_f[$];
  logic [DATAW-1:0] exp_q_r[$];

  always #5 clk = ~clk;

  fifo_level #(.DEPTH_WIDTH(DW), .DATA_WIDTH(DATAW), .FWFT(1),
               .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_dut_fwft (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .wr_data_i(wr_data),
    .wr_en_i(wr_en), .rd_en_i(rd_en), .rd_data_o(rd_data_f),
    .rd_valid_o(rd_valid_f), .full_o(full_f), .empty_o(empty_f),
    .almost_full_o(af_f), .almost_empty_o(ae_f), .level_o(level_f),
    .overflow_o(ovf_f), .underflow_o(unf_f));

  fifo_level #(.DEPTH_WIDTH(DW), .DATA_WIDTH(DATAW), .FWFT(0),
               .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) u_dut_reg (
    .clk(clk), .rst_n(rst_n), .clr_i(clr_i), .wr_data_i(wr_data),
    .wr_en_i(wr_en), .rd_en_i(rd_en), .rd_data_o(rd_data_r),
    .rd_valid_o(rd_valid_r), .full_o(full_r), .empty_o(empty_r),
    .almost_full_o(af_r), .almost_empty_o(ae_r), .level_o(level_r),
    .overflow_o(ovf_r), .underflow_o(unf_r));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Expected status word {level, full, empty, almost_full, almost_empty, ovf, unf}.
  function automatic logic [10:0] model_status();
    int n;
    n = m_q.size();
    return {5'(n), n == DEPTH, n == 0, n >= AF, n <= AE, m_ovf, m_unf};
  endfunction

  // One clock of stimulus; the model advances at the same edge as the DUT.
  task automatic step(input bit wr, input bit rd, input logic [DATAW-1:0] d, input bit clr);
    bit rd_ok, wr_ok;
    wr_en   = wr;
    rd_en   = rd;
    wr_data = d;
    clr_i   = clr;
    rd_ok = rd && (m_q.size() != 0);
    wr_ok = wr && ((m_q.size() < DEPTH) || rd_ok);
    if (!clr && rd_ok) begin
      exp_q_f.push_back(m_q[0]);
      exp_q_r.push_back(m_q[0]);
    end
    @(posedge clk);
    if (clr) begin
      m_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (rd_ok) void'(m_q.pop_front());
      if (wr_ok) m_q.push_back(d);
      if (wr && !wr_ok) m_ovf = 1'b1;
      if (rd && !rd_ok) m_unf = 1'b1;
    end
    #1;
  endtask

  // Asynchronous reset asserted mid-cycle, released just after the next edge.
  task automatic pulse_reset();
    #2;
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    clr_i = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    exp_q_f.delete();
    exp_q_r.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: status every cycle, data popped from the scoreboard on handshakes.
  always @(negedge clk) begin
    logic [10:0] st_exp;
    st_exp = model_status();
    check("status_fwft", {level_f, full_f, empty_f, af_f, ae_f, ovf_f, unf_f}, st_exp);
    check("status_reg",  {level_r, full_r, empty_r, af_r, ae_r, ovf_r, unf_r}, st_exp);
    check("valid_fwft", rd_valid_f, m_q.size() != 0);
    if (rst_n && rd_en && !clr_i && rd_valid_f) begin
      check("fwft_exp_pending", exp_q_f.size() != 0, 1);
      if (exp_q_f.size() != 0) check("fwft_data", rd_data_f, exp_q_f.pop_front());
    end
    if (rd_valid_r) begin
      check("reg_exp_pending", exp_q_r.size() != 0, 1);
      if (exp_q_r.size() != 0) check("reg_data", rd_data_r, exp_q_r.pop_front());
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_level", level_f, 0);
    check("rst_empty", empty_f, 1);
    check("rst_aempty", ae_f, 1);
    check("rst_full", full_r, 0);
    check("rst_errs", {ovf_f, unf_f, ovf_r, unf_r}, 0);
    check("rst_valid_reg", rd_valid_r, 0);
    check("rst_data_reg", rd_data_r, 0);
    check("rst_data_fwft", rd_data_f, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 2: fill to full, then one dropped write
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(i), 0);
    step(0, 0, 0, 0);
    check("fill_level", level_f, DEPTH);
    check("fill_full", full_f, 1);
    step(1, 0, 8'hFF, 0);
    step(0, 0, 0, 0);
    check("ovf_set", ovf_f, 1);
    check("ovf_level", level_r, DEPTH);

    // 3: drain in order, then one rejected read
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("unf_set", unf_f, 1);
    check("drain_empty", empty_r, 1);

    // 4: simultaneous write/read at full; 0xAA must come out 16th
    step(0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 8'(8'h10 + i), 0);
    step(1, 1, 8'hAA, 0);
    step(0, 0, 0, 0);
    check("full_rw_level", level_f, DEPTH);
    check("full_rw_no_ovf", ovf_f, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 0);

    // 5: registered-read latency and write+read into an empty FIFO
    step(1, 0, 8'h5A, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(1, 1, 8'h77, 0);
    step(0, 0, 0, 0);
    check("empty_wr_rd_unf", unf_r, 1);
    check("empty_wr_rd_level", level_r, 1);

    // 6: clr with errors set at level 7, then reset mid-burst
    step(0, 0, 0, 1);
    step(0, 1, 0, 0);
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 8'(8'h40 + i), 0);
    for (int i = 0; i < DEPTH - 7; i++) step(0, 1, 0, 0);
    check("pre_clr_level", level_f, 7);
    step(0, 0, 0, 1);
    check("clr_level", level_f, 0);
    check("clr_errs", {ovf_f, unf_f}, 0);
    for (int i = 0; i < 5; i++) step(1, i % 2 == 1, 8'(8'h90 + i), 0);
    pulse_reset();
    check("rst_mid_level", level_r, 0);
    step(1, 0, 8'h3C, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // Random traffic with phases biased towards full and towards empty
    for (int i = 0; i < 1200; i++) begin
      int pw;
      pw = ((i / 100) % 2 == 0) ? 75 : 30;
      if ($urandom_range(0, 299) == 0) begin
        pulse_reset();
      end else begin
        step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < (100 - pw),
             8'($urandom), $urandom_range(0, 79) == 0);
      end
    end

    repeat (3) step(0, 0, 0, 0);
    check("fwft_scoreboard_drained", exp_q_f.size(), 0);
    check("reg_scoreboard_drained", exp_q_r.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
